// File: rtl/epmp_bus_pkg.sv
// Shared definitions for the EPMP external-bus unit: FSM encodings and the
// width of the debug state port.
package epmp_bus_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } bus_state_e;

endpackage

// File: rtl/epmp_bus_unit_if.sv
// Control-side handshake plus external address/strobe pins of the EPMP bus
// unit. The bidirectional data bus D stays a plain inout port on the unit.
interface epmp_bus_unit_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
) ();

  logic                              Req;
  logic                              Req_Write;
  logic [ADDR_W-1:0]                 Req_Addr;
  logic [DATA_W-1:0]                 Req_WData;
  logic                              Busy;
  logic                              Done;
  logic                              Err;
  logic [DATA_W-1:0]                 RData;
  logic [ADDR_W-1:0]                 A;
  logic                              Read;
  logic                              Write;
  logic                              Mem_Ready;
  logic [epmp_bus_pkg::STATE_W-1:0]  Debug_State;

  // Bus unit side
  modport slave (
    input  Req, Req_Write, Req_Addr, Req_WData, Mem_Ready,
    output Busy, Done, Err, RData, A, Read, Write, Debug_State
  );

  // Control unit / memory side
  modport master (
    output Req, Req_Write, Req_Addr, Req_WData, Mem_Ready,
    input  Busy, Done, Err, RData, A, Read, Write, Debug_State
  );

endinterface

// File: rtl/epmp_bus_wait_cnt.sv
// Saturating ACCESS-phase wait counter. ge_min says the forced minimum wait
// has elapsed; at_max says the current ACCESS cycle is the MAX_WAIT-th one,
// so a timeout taken on it makes ACCESS last exactly MAX_WAIT cycles.
module epmp_bus_wait_cnt #(
  parameter  int MIN_WAIT = 0,
  parameter  int MAX_WAIT = 15,
  localparam int CNT_W    = $clog2(MAX_WAIT + 2)
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             ge_min,
  output logic             at_max
);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_WAIT + 1);

  // Count ACCESS cycles, holding at MAX_WAIT+1 so ge_min stays true forever
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CNT_SAT)) begin
      count <= count + 1'b1;
    end
  end

  assign ge_min = (count >= CNT_W'(MIN_WAIT));
  assign at_max = (count >= CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/epmp_bus_unit.sv
// EPMP external-bus unit: sequences each Req into SETUP / ACCESS / HOLD
// phases on the A/D/Read/Write pins, with MIN_WAIT forced wait states and
// the Mem_Ready handshake. Optional feature macro: EPMP_BUS_TIMEOUT_EN
// (ACCESS aborts with Err after MAX_WAIT cycles without a valid exit).
module epmp_bus_unit
  import epmp_bus_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 16,
  parameter int MIN_WAIT = 0,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              Reset,
  epmp_bus_unit_if.slave    bus,
  inout  wire  [DATA_W-1:0] D
);

  localparam int CNT_W = $clog2(MAX_WAIT + 2);

  bus_state_e        state_reg;
  logic              write_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              d_oe_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              err_reg;
  logic              rd_strobe_reg;
  logic              wr_strobe_reg;

  logic [CNT_W-1:0]  cnt_count;
  logic              cnt_ge_min;
  logic              cnt_at_max;
  logic              exit_ok;
  logic              timeout;
  logic              unused_cnt;

  epmp_bus_wait_cnt #(
    .MIN_WAIT (MIN_WAIT),
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_cnt (
    .clk    (clk),
    .Reset  (Reset),
    .clear  (state_reg == ST_SETUP),
    .enable (state_reg == ST_ACCESS),
    .count  (cnt_count),
    .ge_min (cnt_ge_min),
    .at_max (cnt_at_max)
  );

  // The raw count is only observed through the flags
  assign unused_cnt = ^{cnt_count, cnt_at_max};

  assign exit_ok = bus.Mem_Ready && cnt_ge_min;

`ifdef EPMP_BUS_TIMEOUT_EN
  assign timeout = cnt_at_max && !exit_ok;
`else
  assign timeout = 1'b0;
`endif

  // Transfer sequencer; every pin-level output is a register set on state entry
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_reg     <= ST_IDLE;
      write_reg     <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
      d_oe_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      rd_strobe_reg <= 1'b0;
      wr_strobe_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.Req) begin
            write_reg <= bus.Req_Write;
            addr_reg  <= bus.Req_Addr;
            wdata_reg <= bus.Req_WData;
            d_oe_reg  <= bus.Req_Write;
            busy_reg  <= 1'b1;
            state_reg <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          rd_strobe_reg <= !write_reg;
          wr_strobe_reg <= write_reg;
          state_reg     <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (exit_ok || timeout) begin
            rd_strobe_reg <= 1'b0;
            wr_strobe_reg <= 1'b0;
            done_reg      <= 1'b1;
            err_reg       <= timeout;
            if (!write_reg && exit_ok) begin
              rdata_reg <= D;
            end
            state_reg <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          busy_reg  <= 1'b0;
          d_oe_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign D               = d_oe_reg ? wdata_reg : {DATA_W{1'bz}};
  assign bus.Busy        = busy_reg;
  assign bus.Done        = done_reg;
  assign bus.Err         = err_reg;
  assign bus.RData       = rdata_reg;
  assign bus.A           = addr_reg;
  assign bus.Read        = rd_strobe_reg;
  assign bus.Write       = wr_strobe_reg;
  assign bus.Debug_State = state_reg;

endmodule
